// File: rtl/flip_flop_trio.sv
// ---------------------------------------------------------------------------
// flip_flop_trio
//   A bank of three edge-triggered storage lanes: a D flip-flop, a JK
//   flip-flop and an SR flip-flop. The lanes share one clock and one
//   synchronous reset. Each lane is WIDTH independent bits wide.
//
// Ports
//   clk        : rising-edge clock shared by every flop
//   reset      : synchronous, active-high reset; takes priority over the data inputs
//   D          : D flip-flop data input
//   J, K       : JK flip-flop set-like and reset-like inputs
//   S, R       : SR flip-flop set and reset inputs
//   Q_d/Qn_d   : D flip-flop state and its complement
//   Q_jk/Qn_jk : JK flip-flop state and its complement
//   Q_sr/Qn_sr : SR flip-flop state and its complement
//   sr_invalid : per bit, set when the previous edge saw S=R=1
//
// The Qn outputs are driven by inverting the state registers. They are not
// stored separately, so Q and Qn can never disagree.
// ---------------------------------------------------------------------------
module flip_flop_trio #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q_d,
    output logic [WIDTH-1:0] Qn_d,
    output logic [WIDTH-1:0] Q_jk,
    output logic [WIDTH-1:0] Qn_jk,
    output logic [WIDTH-1:0] Q_sr,
    output logic [WIDTH-1:0] Qn_sr,
    output logic [WIDTH-1:0] sr_invalid
);

    logic [WIDTH-1:0] q_d_r;
    logic [WIDTH-1:0] q_jk_r;
    logic [WIDTH-1:0] q_sr_r;
    logic [WIDTH-1:0] sr_invalid_r;
    logic [WIDTH-1:0] jk_next_s;
    logic [WIDTH-1:0] sr_next_s;

    // Next-state decode for the JK lane, evaluated bit by bit
    always_comb begin
        jk_next_s = q_jk_r;
        for (int i = 0; i < WIDTH; i++) begin
            case ({J[i], K[i]})
                2'b00:   jk_next_s[i] = q_jk_r[i];
                2'b01:   jk_next_s[i] = 1'b0;
                2'b10:   jk_next_s[i] = 1'b1;
                2'b11:   jk_next_s[i] = ~q_jk_r[i];
                default: jk_next_s[i] = q_jk_r[i];
            endcase
        end
    end

    // Next-state decode for the SR lane; S=R=1 resolves reset-dominant (clears)
    always_comb begin
        sr_next_s = q_sr_r;
        for (int i = 0; i < WIDTH; i++) begin
            case ({S[i], R[i]})
                2'b00:   sr_next_s[i] = q_sr_r[i];
                2'b01:   sr_next_s[i] = 1'b0;
                2'b10:   sr_next_s[i] = 1'b1;
                2'b11:   sr_next_s[i] = 1'b0;
                default: sr_next_s[i] = q_sr_r[i];
            endcase
        end
    end

    // State registers for all three lanes plus the forbidden-combination flag
    always_ff @(posedge clk) begin
        if (reset) begin
            q_d_r        <= {WIDTH{1'b0}};
            q_jk_r       <= {WIDTH{1'b0}};
            q_sr_r       <= {WIDTH{1'b0}};
            sr_invalid_r <= {WIDTH{1'b0}};
        end else begin
            q_d_r        <= D;
            q_jk_r       <= jk_next_s;
            q_sr_r       <= sr_next_s;
            sr_invalid_r <= S & R;
        end
    end

    assign Q_d        = q_d_r;
    assign Qn_d       = ~q_d_r;
    assign Q_jk       = q_jk_r;
    assign Qn_jk      = ~q_jk_r;
    assign Q_sr       = q_sr_r;
    assign Qn_sr      = ~q_sr_r;
    assign sr_invalid = sr_invalid_r;

endmodule

// File: tb/tb_flip_flop_trio.sv
// ---------------------------------------------------------------------------
// tb_flip_flop_trio
//   Directed bench for flip_flop_trio. It drives a WIDTH=1 instance and a
//   WIDTH=4 instance that share one clock and one reset. All expected values
//   are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_flip_flop_trio;

    logic       clk;
    logic       reset;

    logic       d1, j1, k1, s1, r1;
    logic       q_d1, qn_d1, q_jk1, qn_jk1, q_sr1, qn_sr1, inv1;

    logic [3:0] d4, j4, k4, s4, r4;
    logic [3:0] q_d4, qn_d4, q_jk4, qn_jk4, q_sr4, qn_sr4, inv4;

    int n_cmp;
    int n_fail;

    flip_flop_trio #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .D(d1), .J(j1), .K(k1), .S(s1), .R(r1),
        .Q_d(q_d1), .Qn_d(qn_d1), .Q_jk(q_jk1), .Qn_jk(qn_jk1),
        .Q_sr(q_sr1), .Qn_sr(qn_sr1), .sr_invalid(inv1)
    );

    flip_flop_trio #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .D(d4), .J(j4), .K(k4), .S(s4), .R(r4),
        .Q_d(q_d4), .Qn_d(qn_d4), .Q_jk(q_jk4), .Qn_jk(qn_jk4),
        .Q_sr(q_sr4), .Qn_sr(qn_sr4), .sr_invalid(inv4)
    );

    // Free-running clock with a 10-unit period; rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks every output of the 1-bit instance; each Qn is expected to be the complement of its Q
    task automatic chk1(input string tag, input logic qd, input logic qjk,
                        input logic qsr, input logic inv);
        check({tag, ".q_d"},   {3'b000, q_d1},   {3'b000, qd});
        check({tag, ".qn_d"},  {3'b000, qn_d1},  {3'b000, ~qd});
        check({tag, ".q_jk"},  {3'b000, q_jk1},  {3'b000, qjk});
        check({tag, ".qn_jk"}, {3'b000, qn_jk1}, {3'b000, ~qjk});
        check({tag, ".q_sr"},  {3'b000, q_sr1},  {3'b000, qsr});
        check({tag, ".qn_sr"}, {3'b000, qn_sr1}, {3'b000, ~qsr});
        check({tag, ".inv"},   {3'b000, inv1},   {3'b000, inv});
    endtask

    // Checks every output of the 4-bit instance; each Qn is expected to be the complement of its Q
    task automatic chk4(input string tag, input logic [3:0] qd, input logic [3:0] qjk,
                        input logic [3:0] qsr, input logic [3:0] inv);
        check({tag, ".q_d"},   q_d4,   qd);
        check({tag, ".qn_d"},  qn_d4,  ~qd);
        check({tag, ".q_jk"},  q_jk4,  qjk);
        check({tag, ".qn_jk"}, qn_jk4, ~qjk);
        check({tag, ".q_sr"},  q_sr4,  qsr);
        check({tag, ".qn_sr"}, qn_sr4, ~qsr);
        check({tag, ".inv"},   inv4,   inv);
    endtask

    task automatic drive1(input logic j, input logic k, input logic s,
                          input logic r, input logic d);
        j1 = j; k1 = k; s1 = s; r1 = r; d1 = d;
    endtask

    // Waits for a rising edge, then a further 1 time unit so that outputs are sampled after the edge has settled
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Reset with random data inputs on both instances
        reset = 1'b1;
        drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        d4 = 4'($urandom); j4 = 4'($urandom); k4 = 4'($urandom);
        s4 = 4'($urandom); r4 = 4'($urandom);
        step();
        chk1("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk4("reset4", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Release reset. The 1-bit instance gets all-zero inputs.
        // The 4-bit instance gets its mixed vector, applied from the reset state:
        //   JK: bit3 J1K1 toggles 0->1, bit2 J1K0 sets to 1, bit1 J0K1 clears, bit0 holds 0 -> 1100
        //   SR: bit3 holds 0, bit2 S=R=1 clears and flags, bit1 sets, bit0 clears -> 0010, flag 0100
        reset = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        d4 = 4'b1010; j4 = 4'b1100; k4 = 4'b1010; s4 = 4'b0110; r4 = 4'b0101;
        step();
        chk1("hold0", 1'b0, 1'b0, 1'b0, 1'b0);
        chk4("vec4a", 4'b1010, 4'b1100, 4'b0010, 4'b0100);

        // Second 4-bit vector: JK toggles every bit, SR sets every bit, D captures 0101
        d4 = 4'b0101; j4 = 4'b1111; k4 = 4'b1111; s4 = 4'b1111; r4 = 4'b0000;
        drive1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk1("clear0", 1'b0, 1'b0, 1'b0, 1'b0);
        chk4("vec4b", 4'b0101, 4'b0011, 4'b1111, 4'b0000);
        d4 = 4'b0000; j4 = 4'b0000; k4 = 4'b0000; s4 = 4'b0000; r4 = 4'b0000;

        // Set all three lanes of the 1-bit instance, then hold
        drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk1("set", 1'b1, 1'b1, 1'b1, 1'b0);
        chk4("hold4", 4'b0000, 4'b0011, 4'b1111, 4'b0000);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk1("hold1", 1'b1, 1'b1, 1'b1, 1'b0);

        // All inputs high for three edges: JK toggles 0,1,0; SR is forced to 0 with the flag raised
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk1("tog1", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk1("tog2", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk1("tog3", 1'b1, 1'b0, 1'b0, 1'b1);

        // Removing the forbidden combination clears the flag; SR holds 0
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk1("forb_clr", 1'b1, 1'b0, 1'b0, 1'b0);

        // Set everything to 1, then raise reset between edges
        drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk1("preset", 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #3;
        chk1("rst_mid", 1'b1, 1'b1, 1'b1, 1'b0);
        chk4("rst_mid4", 4'b0000, 4'b0011, 4'b1111, 4'b0000);
        step();
        chk1("rst_edge", 1'b0, 1'b0, 1'b0, 1'b0);
        chk4("rst_edge4", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Drop reset with J=K=1: the JK lane toggles from 0 to 1
        reset = 1'b0;
        drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk1("post_rst_tog", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
